sync_burst_gen: RTL and testbench

Parametrised multi-channel sync pulse generator for the AFE front end. It waits a programmable delay, then emits one pulse per channel, with each channel offset from the previous one by a fixed stagger. It runs either one-shot or periodic, can be restarted or aborted at runtime, and can auto-arm out of reset. Default parameters keep the legacy single power-up sync pulse timing on `sync[0]`.

---
 rtl/sync_burst_pkg.sv | 14 +
 rtl/sync_down_counter.sv | 28 ++
 rtl/sync_burst_gen.sv | 134 +++++++++++++
 tb/tb_sync_burst_gen.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/sync_burst_pkg.sv
// rtl/sync_burst_pkg.sv - shared state type and burst length helper for sync_burst_gen
package sync_burst_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        BURST = 2'd2
    } sync_state_t;

    function automatic int burst_len(input int num_ch, input int stagger, input int pulse_len);
        return (num_ch - 1) * stagger + pulse_len;
    endfunction

endpackage

// File: rtl/sync_down_counter.sv
// rtl/sync_down_counter.sv - loadable down counter that parks at zero
module sync_down_counter #(
    parameter int               CNT_W       = 20,
    parameter logic [CNT_W-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= RESET_VALUE;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sync_burst_gen.sv
// rtl/sync_burst_gen.sv - delayed, staggered multi-channel sync pulse burst generator
module sync_burst_gen
    import sync_burst_pkg::*;
#(
    parameter int              CNT_W      = 20,
    parameter int              NUM_CH     = 4,
    parameter int              PULSE_LEN  = 1,
    parameter int              STAGGER    = 0,
    parameter bit              AUTO_START = 1'b1,
    parameter longint unsigned INIT_DELAY = 20'hFFFFD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              periodic,
    input  logic [CNT_W-1:0]  delay,
    input  logic [CNT_W-1:0]  period,
    output logic [NUM_CH-1:0] sync,
    output logic              done,
    output logic              busy
);

    localparam int               BURST_LEN  = burst_len(NUM_CH, STAGGER, PULSE_LEN);
    localparam int               PH_W       = $clog2(BURST_LEN + 1);
    localparam logic [PH_W-1:0]  LAST_PHASE = PH_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_RESET  = AUTO_START ? CNT_W'(INIT_DELAY) : '0;

    if (NUM_CH < 1) begin : g_chk_num_ch
        $error("sync_burst_gen: NUM_CH must be at least 1");
    end
    if (PULSE_LEN < 1) begin : g_chk_pulse_len
        $error("sync_burst_gen: PULSE_LEN must be at least 1");
    end
    if (STAGGER < 0) begin : g_chk_stagger
        $error("sync_burst_gen: STAGGER must not be negative");
    end
    if ((CNT_W < 64) && (INIT_DELAY >= (64'd1 << CNT_W))) begin : g_chk_init_delay
        $error("sync_burst_gen: INIT_DELAY does not fit in CNT_W bits");
    end

    sync_state_t       state;
    sync_state_t       state_next;
    logic [PH_W-1:0]   phase;
    logic [PH_W-1:0]   phase_next;
    int                phase_i;
    logic [NUM_CH-1:0] sync_next;
    logic              done_next;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero;
    logic [CNT_W-1:0]  cnt_load_value;

    sync_down_counter #(
        .CNT_W       (CNT_W),
        .RESET_VALUE (CNT_RESET)
    ) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= AUTO_START ? DELAY : IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_next = DELAY;
                DELAY:   if (cnt_zero) state_next = BURST;
                BURST:   if (phase == LAST_PHASE) state_next = periodic ? DELAY : IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    assign phase_i = int'(phase);

    // Abort suppresses every load and output so the next edge lands cleanly in IDLE.
    always_comb begin
        cnt_load       = 1'b0;
        cnt_load_value = delay;
        cnt_dec        = 1'b0;
        phase_next     = '0;
        sync_next      = '0;
        done_next      = 1'b0;
        if (!abort) begin
            case (state)
                IDLE:  cnt_load = start;
                DELAY: cnt_dec  = !cnt_zero;
                BURST: begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        sync_next[c] = (phase_i >= c * STAGGER) &&
                                       (phase_i < c * STAGGER + PULSE_LEN);
                    end
                    if (phase == LAST_PHASE) begin
                        done_next      = !periodic;
                        cnt_load       = periodic;
                        cnt_load_value = period;
                    end else begin
                        phase_next = phase + PH_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= '0;
            sync  <= '0;
            done  <= 1'b0;
        end else begin
            phase <= phase_next;
            sync  <= sync_next;
            done  <= done_next;
        end
    end

    assign busy = (state != IDLE) | (|sync);

endmodule

// File: tb/tb_sync_burst_gen.sv
// tb/tb_sync_burst_gen.sv - scoreboard bench for sync_burst_gen
`timescale 1ns/1ps
module tb_sync_burst_gen;

    localparam int CNT_W = 20;
    localparam int NCH   = 4;
    localparam int STG   = 3;
    localparam int PLEN  = 2;
    localparam int BL    = 11;
    localparam int INITD = 10;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             periodic = 1'b0;
    logic [CNT_W-1:0] delay = '0;
    logic [CNT_W-1:0] period = '0;
    logic [NCH-1:0]   sync_a;
    logic             done_a;
    logic             busy_a;

    logic             start_b = 1'b0;
    logic             abort_b = 1'b0;
    logic             periodic_b = 1'b0;
    logic [CNT_W-1:0] delay_b = '0;
    logic [CNT_W-1:0] period_b = '0;
    logic [0:0]       sync_b;
    logic             done_b;
    logic             busy_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [5:0] exp_a[$];
    logic [2:0] exp_b[$];

    always #5 clk = ~clk;

    sync_burst_gen #(
        .CNT_W(CNT_W), .NUM_CH(NCH), .PULSE_LEN(PLEN), .STAGGER(STG),
        .AUTO_START(1'b0), .INIT_DELAY(64'd0)
    ) dut_a (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .periodic(periodic),
        .delay(delay), .period(period), .sync(sync_a), .done(done_a), .busy(busy_a)
    );

    sync_burst_gen #(
        .CNT_W(CNT_W), .NUM_CH(1), .PULSE_LEN(1), .STAGGER(0),
        .AUTO_START(1'b1), .INIT_DELAY(64'(INITD))
    ) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .abort(abort_b), .periodic(periodic_b),
        .delay(delay_b), .period(period_b), .sync(sync_b), .done(done_b), .busy(busy_b)
    );

    // Expected {busy, done, sync} after edge e, where edge 0 samples start.
    function automatic logic [5:0] model_a(input int e, input int d, input bit per_mode,
                                           input int per, input int kill_e);
        logic [3:0] s;
        logic       dn;
        logic       bz;
        int         p;
        s  = '0;
        dn = 1'b0;
        if (kill_e >= 0 && e >= kill_e) return 6'b0;
        bz = per_mode ? 1'b1 : (e <= d + BL + 1);
        p  = e - (d + 2);
        if (p >= 0) begin
            if (per_mode) p = p % (BL + per + 1);
            if (p < BL) begin
                for (int c = 0; c < NCH; c++) s[c] = (p >= c * STG) && (p < c * STG + PLEN);
                dn = !per_mode && (p == BL - 1);
            end
        end
        return {bz, dn, s};
    endfunction

    task automatic check_a(input string tag, input int e);
        logic [5:0] exp;
        logic [5:0] obs;
        exp = exp_a.pop_front();
        obs = {busy_a, done_a, sync_a};
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s edge %0d observed busy/done/sync=%b expected %b", tag, e, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input int e);
        logic [2:0] exp;
        logic [2:0] obs;
        exp = exp_b.pop_front();
        obs = {busy_b, done_b, sync_b};
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s edge %0d observed busy/done/sync=%b expected %b", tag, e, obs, exp);
        end
    endtask

    // kill_e is the edge sampling abort (or reset when kill_rst); x1/x2 are extra start edges.
    task automatic run_a(input string tag, input int d, input bit per_mode, input int per,
                         input int kill_e, input bit kill_rst, input int x1, input int x2,
                         input int n);
        for (int e = 0; e <= n; e++) exp_a.push_back(model_a(e, d, per_mode, per, kill_e));
        delay    = CNT_W'(d);
        period   = CNT_W'(per);
        periodic = per_mode;
        start    = 1'b1;
        for (int e = 0; e <= n; e++) begin
            @(posedge clk);
            #1;
            start = (e + 1 == x1) || (e + 1 == x2);
            abort = !kill_rst && (e + 1 == kill_e);
            reset = kill_rst && (e + 1 == kill_e);
            check_a(tag, e);
        end
        start    = 1'b0;
        abort    = 1'b0;
        reset    = 1'b0;
        periodic = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        exp_a.push_back(6'b0);
        exp_b.push_back(3'b100);
        check_a("reset_a", 0);
        check_b("reset_b", 0);
        reset = 1'b0;

        for (int e = 1; e <= 20; e++) exp_b.push_back({e <= INITD + 2, e == INITD + 2, e == INITD + 2});
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            check_b("auto_start", e);
        end

        run_a("oneshot",       5, 1'b0, 0, -1, 1'b0, -1, -1, 22);
        run_a("start_ignored", 5, 1'b0, 0, -1, 1'b0,  3,  9, 22);
        run_a("delay_zero",    0, 1'b0, 0, -1, 1'b0, -1, -1, 16);
        run_a("periodic",      5, 1'b1, 2, 40, 1'b0, -1, -1, 44);
        run_a("abort",         5, 1'b0, 0, 13, 1'b0, 13, -1, 22);
        run_a("reset_mid",     5, 1'b0, 0,  9, 1'b1, -1, -1, 14);

        exp_b.push_back(3'b100);
        check_b("b_after_reset", 14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
